// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between a byte producer, the transmit FIFO and the UART transmitter.
// The master side writes bytes and returns tx_complete; the slave side is the FIFO.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          tx_complete;
  logic          tx_en;
  logic [7:0]    tx_byte;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;

  modport master (
    output wr_en, wr_data, flush, tx_complete,
    input  tx_en, tx_byte, full, empty, count, overflow, busy
  );

  modport slave (
    input  wr_en, wr_data, flush, tx_complete,
    output tx_en, tx_byte, full, empty, count, overflow, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues pushed bytes and hands them out one at a
// time with an active-low start strobe, waiting for the transmitter's done pulse.
//
// state | meaning
// IDLE  | nothing in flight; pops the head byte when the queue is non-empty
// START | byte latched on tx_byte; tx_en is driven low on the way out of this state
// WAIT  | byte in flight; leaves on tx_complete
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic          sourceClk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_next;

  logic          push;
  logic          pop;
  logic          drop;

  logic          tx_en_q;
  logic [7:0]    tx_byte_q;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          busy_q;

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A pop only happens from IDLE and is suppressed by flush; flush never moves the FSM.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush && (count_q != '0)) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (bus.tx_complete) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A full queue still accepts a byte when the head leaves in the same cycle.
  always_comb begin
    push = bus.wr_en && !bus.flush && (!full_q || pop);
    drop = bus.wr_en && !bus.flush && full_q && !pop;
    if (bus.flush) begin
      count_next = '0;
    end else begin
      count_next = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge sourceClk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_next;
    end
  end

  // tx_en follows the state one edge late, so the low pulse lands the cycle after START.
  always_ff @(posedge sourceClk or negedge reset) begin
    if (!reset) begin
      tx_en_q    <= 1'b1;
      tx_byte_q  <= 8'h00;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_en_q    <= (state != START);
      if (pop) begin
        tx_byte_q <= mem[rd_ptr];
      end
      full_q     <= (count_next == DEPTH_CNT);
      empty_q    <= (count_next == '0);
      overflow_q <= drop;
      busy_q     <= (state_next != IDLE);
    end
  end

  assign bus.tx_en    = tx_en_q;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic sourceClk;
  logic reset;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .sourceClk (sourceClk),
    .reset     (reset),
    .bus       (bus)
  );

  initial sourceClk = 1'b0;
  always #5 sourceClk = ~sourceClk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pulse;
  logic [7:0] got_q[$];
  logic [7:0] push_q[$];

  // reference model state
  logic [7:0] mq[$];
  int         m_age;
  logic [7:0] m_byte;
  logic       m_ovf;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       fl;
    logic       tc;
    logic [4:0] cnt;
    logic       txen;
    logic       bsy;
    logic [7:0] tb;
    logic       ovf;
  } vec_t;

  vec_t vt[13];

  task automatic tick();
    @(posedge sourceClk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en       = 1'b0;
    bus.wr_data     = 8'h00;
    bus.flush       = 1'b0;
    bus.tx_complete = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_age  = -1;
    m_byte = 8'h00;
    m_ovf  = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_reset();
  endtask

  // age = edges since the last pop, -1 when nothing is in flight, saturating at 2
  task automatic model_step(input logic wr, input logic [7:0] d, input logic fl, input logic tc);
    int   n;
    logic p;
    n     = mq.size();
    p     = (m_age < 0) && !fl && (n != 0);
    m_ovf = wr && !fl && (n == DEPTH) && !p;
    if (p) m_age = 0;
    else if (m_age >= 1 && tc) m_age = -1;
    else if (m_age >= 0 && m_age < 2) m_age++;
    if (fl) begin
      mq.delete();
    end else begin
      if (p) m_byte = mq.pop_front();
      if (wr && (n < DEPTH || p)) mq.push_back(d);
    end
  endtask

  task automatic check_model();
    chk("rnd_count", 32'(bus.count), 32'(mq.size()));
    chk("rnd_full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("rnd_empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("rnd_overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("rnd_busy", 32'(bus.busy), 32'(m_age >= 0));
    chk("rnd_tx_en", 32'(bus.tx_en), 32'(m_age != 1));
    chk("rnd_tx_byte", 32'(bus.tx_byte), 32'(m_byte));
  endtask

  // Pushes push_q one byte per cycle, answers each tx_en pulse with tx_complete 20 cycles later.
  task automatic drain(input int budget);
    int cd;
    bit done;
    cd      = -1;
    done    = 1'b0;
    n_pulse = 0;
    got_q.delete();
    for (int c = 0; c < budget && !done; c++) begin
      bus.tx_complete = (cd == 0);
      if (cd >= 0) cd--;
      if (push_q.size() > 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_data = push_q.pop_front();
      end else begin
        bus.wr_en = 1'b0;
      end
      tick();
      if (bus.tx_en == 1'b0) begin
        got_q.push_back(bus.tx_byte);
        n_pulse++;
        cd = 20;
      end
      if (!bus.busy && bus.empty && cd < 0 && push_q.size() == 0) done = 1'b1;
    end
    idle_inputs();
    chk("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h55, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 8'h55, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h55, 1'b0};
    vt[4]  = '{1'b1, 8'h66, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 8'h55, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 8'h55, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h66, 1'b0};
    vt[7]  = '{1'b1, 8'h77, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h66, 1'b0};
    vt[8]  = '{1'b1, 8'h88, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 8'h66, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h66, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h66, 1'b0};
    vt[11] = '{1'b1, 8'h99, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0, 8'h66, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h99, 1'b0};

    // reset state, sampled while reset is held
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_tx_en", 32'(bus.tx_en), 32'd1);
    chk("rst_tx_byte", 32'(bus.tx_byte), 32'h00);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;

    // vector table
    for (int i = 0; i < 13; i++) begin
      bus.wr_en       = vt[i].wr;
      bus.wr_data     = vt[i].d;
      bus.flush       = vt[i].fl;
      bus.tx_complete = vt[i].tc;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vt[i].cnt == 0));
      chk($sformatf("vec%0d_tx_en", i), 32'(bus.tx_en), 32'(vt[i].txen));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vt[i].bsy));
      chk($sformatf("vec%0d_tx_byte", i), 32'(bus.tx_byte), 32'(vt[i].tb));
      chk($sformatf("vec%0d_overflow", i), 32'(bus.overflow), 32'(vt[i].ovf));
    end
    idle_inputs();

    // overflow with the FSM parked in WAIT, then simultaneous push/pop while full
    reset_dut();
    bus.wr_en = 1'b1; bus.wr_data = 8'hC0;
    tick();
    bus.wr_en = 1'b0;
    tick();
    tick();
    chk("park_tx_en_low", 32'(bus.tx_en), 32'd0);
    for (int i = 0; i < 17; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      tick();
      chk($sformatf("fill%0d_count", i), 32'(bus.count), 32'((i < 16) ? i + 1 : 16));
      chk($sformatf("fill%0d_full", i), 32'(bus.full), 32'(i >= 15));
      chk($sformatf("fill%0d_overflow", i), 32'(bus.overflow), 32'(i == 16));
    end
    idle_inputs();
    tick();
    chk("ovf_one_cycle", 32'(bus.overflow), 32'd0);
    chk("ovf_count_kept", 32'(bus.count), 32'd16);
    bus.tx_complete = 1'b1;
    tick();
    bus.tx_complete = 1'b0;
    chk("full_idle_busy", 32'(bus.busy), 32'd0);
    chk("full_idle_full", 32'(bus.full), 32'd1);
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    tick();
    idle_inputs();
    chk("pushpop_count", 32'(bus.count), 32'd16);
    chk("pushpop_overflow", 32'(bus.overflow), 32'd0);
    chk("pushpop_tx_byte", 32'(bus.tx_byte), 32'h00);
    drain(2000);
    chk("full_drain_pulses", 32'(n_pulse), 32'd17);
    chk("full_drain_len", 32'(got_q.size()), 32'd17);
    for (int i = 0; i < got_q.size() && i < 17; i++)
      chk($sformatf("full_drain_byte%0d", i), 32'(got_q[i]), (i < 16) ? 32'(i) : 32'hEE);

    // three bytes with a slow transmitter
    reset_dut();
    push_q = '{8'hA1, 8'hA2, 8'hA3};
    drain(500);
    chk("seq3_pulses", 32'(n_pulse), 32'd3);
    chk("seq3_len", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < got_q.size() && i < 3; i++)
      chk($sformatf("seq3_byte%0d", i), 32'(got_q[i]), 32'(8'hA1 + i));
    chk("seq3_count", 32'(bus.count), 32'd0);
    chk("seq3_empty", 32'(bus.empty), 32'd1);

    // flush while a byte is in flight
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i);
      tick();
    end
    idle_inputs();
    chk("preflush_count", 32'(bus.count), 32'd5);
    chk("preflush_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("flush_busy_held", 32'(bus.busy), 32'd1);
    bus.tx_complete = 1'b1;
    tick();
    bus.tx_complete = 1'b0;
    chk("flush_done_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("flush_no_pulse", 32'(bus.tx_en), 32'd1);
    end

    // asynchronous reset in WAIT
    reset_dut();
    bus.wr_en = 1'b1; bus.wr_data = 8'h11;
    tick();
    bus.wr_en = 1'b0;
    tick();
    tick();
    bus.wr_en = 1'b1; bus.wr_data = 8'h22;
    tick();
    bus.wr_en = 1'b0;
    chk("prerst_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_tx_en", 32'(bus.tx_en), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_no_pop", 32'(bus.busy), 32'd0);
    end
    push_q = '{8'h3C};
    drain(200);
    chk("postrst_len", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("postrst_byte", 32'(got_q[0]), 32'h3C);

    // randomized run against the reference model
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      logic       r_wr, r_fl, r_tc;
      logic [7:0] r_d;
      r_wr = ($urandom_range(99) < 60);
      r_d  = 8'($urandom);
      r_fl = ($urandom_range(99) < 2);
      r_tc = ($urandom_range(99) < ((((c / 400) % 2) == 0) ? 4 : 45));
      bus.wr_en       = r_wr;
      bus.wr_data     = r_d;
      bus.flush       = r_fl;
      bus.tx_complete = r_tc;
      model_step(r_wr, r_d, r_fl, r_tc);
      tick();
      check_model();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
